// File: rtl/mul_div_pkg.sv
// Shared types and constants for the parametrised multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Wide enough to hold the larger of the divide iteration count and the multiply depth.
  function automatic int cnt_width(input int w, input int stages);
    int m;
    m = (w > stages) ? w : stages;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mul_div_param_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface mul_div_param_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      start;
  logic                      mul0_div1;
  logic                      x_signed0_unsigned1;
  logic                      y_signed0_unsigned1;
  logic [DATA_WIDTH-1:0]     x;
  logic [DATA_WIDTH-1:0]     y;
  logic                      flush;
  logic                      ready;
  logic                      valid_out;
  logic [2*DATA_WIDTH-1:0]   z;
  logic                      div_by_zero;
  logic                      ov;

  modport master (
    output start, mul0_div1, x_signed0_unsigned1, y_signed0_unsigned1, x, y, flush,
    input  ready, valid_out, z, div_by_zero, ov
  );

  modport slave (
    input  start, mul0_div1, x_signed0_unsigned1, y_signed0_unsigned1, x, y, flush,
    output ready, valid_out, z, div_by_zero, ov
  );
endinterface

// File: rtl/div_restoring_iter.sv
// Radix-2 restoring divider datapath on magnitudes; one quotient bit per step, MSB first.
module div_restoring_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_r
);

  logic [W-1:0] r_q;
  logic [W-1:0] r_rem;
  logic [W-1:0] r_divisor;
  logic [W:0]   w_partial;
  logic         w_fits;
  logic [W-1:0] w_diff;

  // The shifted remainder is below 2*divisor, so a W-bit subtract is exact whenever it fits.
  assign w_partial = {r_rem, r_q[W-1]};
  assign w_fits    = (w_partial >= {1'b0, r_divisor});
  assign w_diff    = w_partial[W-1:0] - r_divisor;

  // Shift/trial-subtract register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q       <= {W{1'b0}};
      r_rem     <= {W{1'b0}};
      r_divisor <= {W{1'b0}};
    end else if (i_load) begin
      r_q       <= i_dividend;
      r_rem     <= {W{1'b0}};
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_rem     <= w_fits ? w_diff : w_partial[W-1:0];
      r_q       <= {r_q[W-2:0], w_fits};
    end else begin
      r_q       <= r_q;
      r_rem     <= r_rem;
      r_divisor <= r_divisor;
    end
  end

  assign o_q = r_q;
  assign o_r = r_rem;

endmodule

// File: rtl/mul_div_param.sv
// Multiply/divide unit: pipelined signed/unsigned multiply, iterative restoring divide
// with RISC-V divide-by-zero/overflow results, and flush.
module mul_div_param
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STAGES = 2
) (
  input logic             clk,
  input logic             reset_n,
  mul_div_param_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH, MUL_STAGES);
  localparam logic [CW-1:0]  DIV_CNT_INIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  MUL_CNT_INIT = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0]  CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ONE_W        = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W       = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   MOST_NEG     = {1'b1, {(W-1){1'b0}}};

  state_e                           r_state;
  logic [CW-1:0]                    r_cnt;
  logic                             r_ready;
  logic                             r_valid;
  logic                             r_dbz;
  logic                             r_ov;
  logic [2*W-1:0]                   r_z;
  logic [2*W-1:0]                   r_res;
  logic                             r_res_dbz;
  logic                             r_res_ov;
  logic                             r_op_div;
  logic                             r_res_neg;
  logic                             r_rem_neg;
  logic [W-1:0]                     r_a;
  logic [W-1:0]                     r_b;
  logic [MUL_STAGES-1:0][2*W-1:0]   r_pipe;

  logic           w_accept;
  logic           w_x_neg;
  logic           w_y_neg;
  logic [W-1:0]   w_x_mag;
  logic [W-1:0]   w_y_mag;
  logic           w_dbz;
  logic           w_ovf;
  logic           w_div_load;
  logic [W-1:0]   w_q;
  logic [W-1:0]   w_r;
  logic [W-1:0]   w_q_fix;
  logic [W-1:0]   w_r_fix;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_last_in;
  logic [2*W-1:0] w_last_fix;

  // A start coinciding with flush is dropped even in IDLE.
  assign w_accept   = bus.start & r_ready & ~bus.flush;
  assign w_x_neg    = ~bus.x_signed0_unsigned1 & bus.x[W-1];
  assign w_y_neg    = ~bus.y_signed0_unsigned1 & bus.y[W-1];
  assign w_x_mag    = w_x_neg ? (~bus.x + ONE_W) : bus.x;
  assign w_y_mag    = w_y_neg ? (~bus.y + ONE_W) : bus.y;
  assign w_dbz      = (bus.y == {W{1'b0}});
  assign w_ovf      = ~bus.x_signed0_unsigned1 & ~bus.y_signed0_unsigned1 &
                      (bus.x == MOST_NEG) & (bus.y == {W{1'b1}});
  assign w_div_load = w_accept & (bus.mul0_div1 == OP_DIV) & ~w_dbz & ~w_ovf;

  assign w_q_fix    = r_res_neg ? (~w_q + ONE_W) : w_q;
  assign w_r_fix    = r_rem_neg ? (~w_r + ONE_W) : w_r;

  assign w_prod     = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

  if (MUL_STAGES == 1) begin : g_one_stage
    assign w_last_in = w_prod;
  end else begin : g_multi_stage
    assign w_last_in = r_pipe[MUL_STAGES-2];
  end
  assign w_last_fix = r_res_neg ? (~w_last_in + ONE_2W) : w_last_in;

  div_restoring_iter #(.W(W)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_div_load),
    .i_step     (r_state == DIV),
    .i_dividend (w_x_mag),
    .i_divisor  (w_y_mag),
    .o_q        (w_q),
    .o_r        (w_r)
  );

  // Product pipeline; the magnitude product is 2W wide so sign fix-up in the last stage is exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= '{default: {(2*W){1'b0}}};
    end else if (r_state == MUL) begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_pipe[MUL_STAGES-1] <= w_last_fix;
    end else begin
      r_pipe <= r_pipe;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= {CW{1'b0}};
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_dbz     <= 1'b0;
      r_ov      <= 1'b0;
      r_z       <= {(2*W){1'b0}};
      r_res     <= {(2*W){1'b0}};
      r_res_dbz <= 1'b0;
      r_res_ov  <= 1'b0;
      r_op_div  <= 1'b0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_a       <= {W{1'b0}};
      r_b       <= {W{1'b0}};
    end else if (bus.flush && (r_state != IDLE)) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready   <= 1'b0;
            r_op_div  <= bus.mul0_div1;
            r_res_neg <= w_x_neg ^ w_y_neg;
            r_rem_neg <= w_x_neg;
            r_a       <= w_x_mag;
            r_b       <= w_y_mag;
            r_res_dbz <= 1'b0;
            r_res_ov  <= 1'b0;
            if (bus.mul0_div1 == OP_MUL) begin
              r_cnt   <= MUL_CNT_INIT;
              r_state <= MUL;
            end else if (w_dbz) begin
              r_res     <= {{W{1'b1}}, bus.x};
              r_res_dbz <= 1'b1;
              r_state   <= DONE;
            end else if (w_ovf) begin
              r_res    <= {bus.x, {W{1'b0}}};
              r_res_ov <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_cnt   <= DIV_CNT_INIT;
              r_state <= DIV;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        MUL: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        DIV: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        FIX: begin
          r_res   <= {w_q_fix, w_r_fix};
          r_state <= DONE;
        end
        DONE: begin
          r_z     <= r_op_div ? r_res : r_pipe[MUL_STAGES-1];
          r_dbz   <= r_res_dbz;
          r_ov    <= r_res_ov;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.valid_out   = r_valid;
  assign bus.z           = r_z;
  assign bus.div_by_zero = r_dbz;
  assign bus.ov          = r_ov;

endmodule

// File: tb/tb_mul_div_param.sv
// Directed self-checking bench for mul_div_param at W = 32, MUL_STAGES = 2.
module tb_mul_div_param;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] last_z;

  always #5 clk = ~clk;

  mul_div_param_if #(.DATA_WIDTH(32)) mdif ();

  mul_div_param #(.DATA_WIDTH(32), .MUL_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mdif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic div, input logic xu, input logic yu,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [63:0] exp_z, input logic exp_dbz, input logic exp_ov);
    int   cyc;
    logic seen;
    @(negedge clk);
    mdif.start = 1'b1;
    mdif.mul0_div1 = div;
    mdif.x_signed0_unsigned1 = xu;
    mdif.y_signed0_unsigned1 = yu;
    mdif.x = a;
    mdif.y = b;
    @(posedge clk);
    #1;
    mdif.start = 1'b0;
    check({tag, "_busy"}, 64'(mdif.ready), 64'd0);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = mdif.valid_out;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_z"}, mdif.z, exp_z);
    check({tag, "_dbz"}, 64'(mdif.div_by_zero), 64'(exp_dbz));
    check({tag, "_ov"}, 64'(mdif.ov), 64'(exp_ov));
    check({tag, "_rdy"}, 64'(mdif.ready), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(mdif.valid_out), 64'd0);
    check({tag, "_hold"}, mdif.z, exp_z);
    last_z = exp_z;
  endtask

  initial begin
    int nv;
    reset_n = 1'b0;
    mdif.start = 1'b0;
    mdif.mul0_div1 = 1'b0;
    mdif.x_signed0_unsigned1 = 1'b0;
    mdif.y_signed0_unsigned1 = 1'b0;
    mdif.x = 32'd0;
    mdif.y = 32'd0;
    mdif.flush = 1'b0;
    #12;
    check("rst_ready", 64'(mdif.ready), 64'd1);
    check("rst_valid", 64'(mdif.valid_out), 64'd0);
    check("rst_z", mdif.z, 64'd0);
    check("rst_flags", {62'd0, mdif.div_by_zero, mdif.ov}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Multiply
    run_op("mul_s_m3x5", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 3, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
    run_op("mul_u_max", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
    run_op("mul_s_minsq", 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 3, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    run_op("mul_mixed", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    // Divide
    run_op("div_s_m7d2", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 34, 64'hFFFF_FFFD_FFFF_FFFF, 1'b0, 1'b0);
    run_op("div_u_big", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 64'h7FFF_FFFC_0000_0001, 1'b0, 1'b0);
    run_op("div_s_7dm2", 1'b1, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE, 34, 64'hFFFF_FFFD_0000_0001, 1'b0, 1'b0);
    run_op("div_17d0", 1'b1, 1'b0, 1'b0, 32'd17, 32'd0, 1, 64'hFFFF_FFFF_0000_0011, 1'b1, 1'b0);
    run_op("div_ovf", 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("div_u_noovf", 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    run_op("div_min_d0", 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);

    // Flush mid-divide: no result, outputs keep the previous result
    @(negedge clk);
    mdif.start = 1'b1;
    mdif.mul0_div1 = 1'b1;
    mdif.x_signed0_unsigned1 = 1'b0;
    mdif.y_signed0_unsigned1 = 1'b0;
    mdif.x = 32'd1000;
    mdif.y = 32'd3;
    @(posedge clk);
    #1;
    mdif.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    mdif.flush = 1'b1;
    @(posedge clk);
    #1;
    mdif.flush = 1'b0;
    check("flush_ready", 64'(mdif.ready), 64'd1);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (mdif.valid_out) nv++;
    end
    check("flush_novalid", 64'(nv), 64'd0);
    check("flush_zkeep", mdif.z, last_z);
    check("flush_dbzkeep", 64'(mdif.div_by_zero), 64'd1);
    run_op("div_100d7", 1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 34, 64'h0000_000E_0000_0002, 1'b0, 1'b0);

    // Flush in IDLE drops a simultaneous start
    @(negedge clk);
    mdif.start = 1'b1;
    mdif.flush = 1'b1;
    mdif.mul0_div1 = 1'b0;
    mdif.x = 32'd3;
    mdif.y = 32'd3;
    @(posedge clk);
    #1;
    mdif.start = 1'b0;
    mdif.flush = 1'b0;
    check("idleflush_rdy", 64'(mdif.ready), 64'd1);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (mdif.valid_out) nv++;
    end
    check("idleflush_novalid", 64'(nv), 64'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    mdif.start = 1'b1;
    mdif.x = 32'd6;
    mdif.y = 32'd7;
    @(posedge clk);
    #1;
    mdif.start = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 64'(mdif.ready), 64'd1);
    check("midrst_z", mdif.z, 64'd0);
    check("midrst_valid", 64'(mdif.valid_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Start held high: a new multiply is taken every L+1 = 4 cycles
    @(negedge clk);
    mdif.start = 1'b1;
    mdif.mul0_div1 = 1'b0;
    mdif.x_signed0_unsigned1 = 1'b0;
    mdif.y_signed0_unsigned1 = 1'b0;
    mdif.x = 32'd6;
    mdif.y = 32'd7;
    @(posedge clk);
    nv = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("b2b_busy", 64'(mdif.ready), 64'd0);
      if (mdif.valid_out) begin
        nv++;
        check("b2b_z", mdif.z, 64'd42);
        check("b2b_slot", 64'(k % 4), 64'd3);
      end
    end
    mdif.start = 1'b0;
    check("b2b_count", 64'(nv), 64'd3);
    repeat (6) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
